// File: rtl/uart_mmio_pkg.sv
// Shared register map, status/control bit positions and TX sequencer states
// for the memory-mapped UART controller.
package uart_mmio_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_HOLD_VALID = 2;
    localparam int ST_RX_OVERRUN = 3;
    localparam int ST_TX_BUSY    = 4;
    localparam int ST_TX_DROP    = 5;
    localparam int ST_TX_ACTIVE  = 6;
    localparam int ST_W          = 7;

    localparam int CTRL_RX_IE = 0;
    localparam int CTRL_TX_IE = 1;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_ISSUE = 2'd1,
        TX_GUARD = 2'd2,
        TX_DRAIN = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read port.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// CPU-facing UART controller: TX FIFO with issue/guard/drain sequencer, one-byte
// RX holding register, sticky error bits and a level interrupt.
module uart_mmio_ctrl
    import uart_mmio_pkg::*;
#(
    parameter int TX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_we,
    input  logic        bus_re,
    output logic [31:0] bus_rdata,
    output logic        irq,
    output logic [7:0]  tx_data,
    output logic        tx_we,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_re
);

    tx_state_e      state;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_pop;
    logic [7:0]     fifo_head;
    logic [7:0]     hold;
    logic           hold_valid;
    logic           rx_overrun;
    logic           tx_drop;
    logic           rx_ie;
    logic           tx_ie;
    logic [ST_W-1:0] status_bits;

    logic wr_data, wr_status, wr_ctrl, rd_data;
    logic capture, overrun_evt, drop_evt;
    logic unused_wdata;

    assign wr_data   = bus_we && (bus_addr == ADDR_DATA)   && !rst;
    assign wr_status = bus_we && (bus_addr == ADDR_STATUS) && !rst;
    assign wr_ctrl   = bus_we && (bus_addr == ADDR_CTRL)   && !rst;
    assign rd_data   = bus_re && (bus_addr == ADDR_DATA)   && !rst;

    // rx_re still high means the UART has not yet retired the byte we just took
    assign capture     = rx_valid && !rx_re;
    assign overrun_evt = capture && hold_valid && !rd_data;
    assign fifo_pop    = (state == TX_ISSUE);
    assign drop_evt    = wr_data && fifo_full && !fifo_pop;

    assign unused_wdata = ^bus_wdata[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_data),
        .wdata (bus_wdata[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        status_bits                = '0;
        status_bits[ST_TX_FULL]    = fifo_full;
        status_bits[ST_TX_EMPTY]   = fifo_empty;
        status_bits[ST_HOLD_VALID] = hold_valid;
        status_bits[ST_RX_OVERRUN] = rx_overrun;
        status_bits[ST_TX_BUSY]    = tx_busy;
        status_bits[ST_TX_DROP]    = tx_drop;
        status_bits[ST_TX_ACTIVE]  = (state != TX_IDLE);
    end

    always_comb begin
        bus_rdata = '0;
        case (bus_addr)
            ADDR_DATA:   if (hold_valid) bus_rdata = {24'b0, hold};
            ADDR_STATUS: bus_rdata = {{(32-ST_W){1'b0}}, status_bits};
            ADDR_CTRL:   bus_rdata = {30'b0, tx_ie, rx_ie};
            default:     bus_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= TX_IDLE;
            tx_we      <= 1'b0;
            tx_data    <= '0;
            rx_re      <= 1'b0;
            hold       <= '0;
            hold_valid <= 1'b0;
            rx_overrun <= 1'b0;
            tx_drop    <= 1'b0;
            rx_ie      <= 1'b0;
            tx_ie      <= 1'b0;
            irq        <= 1'b0;
        end else begin
            tx_we <= 1'b0;
            case (state)
                TX_IDLE: begin
                    if (!fifo_empty && !tx_busy) begin
                        state   <= TX_ISSUE;
                        tx_we   <= 1'b1;
                        tx_data <= fifo_head;
                    end
                end
                TX_ISSUE: state <= TX_GUARD;
                TX_GUARD: state <= TX_DRAIN;
                TX_DRAIN: if (!tx_busy) state <= TX_IDLE;
                default:  state <= TX_IDLE;
            endcase

            rx_re <= capture;
            if (capture) begin
                hold       <= rx_data;
                hold_valid <= 1'b1;
            end else if (rd_data) begin
                hold_valid <= 1'b0;
            end

            // set events take priority over write-1-to-clear
            if (overrun_evt)
                rx_overrun <= 1'b1;
            else if (wr_status && bus_wdata[ST_RX_OVERRUN])
                rx_overrun <= 1'b0;

            if (drop_evt)
                tx_drop <= 1'b1;
            else if (wr_status && bus_wdata[ST_TX_DROP])
                tx_drop <= 1'b0;

            if (wr_ctrl) begin
                rx_ie <= bus_wdata[CTRL_RX_IE];
                tx_ie <= bus_wdata[CTRL_TX_IE];
            end

            irq <= (rx_ie && hold_valid) || (tx_ie && fifo_empty && (state == TX_IDLE));
        end
    end

endmodule
